// File: rtl/sound_engine.sv
// rtl/sound_engine.sv - multi-channel sawtooth tone generator with mute and DAC output
//
// Purpose:
//   CHANNELS independent tone channels. A rising edge on trig[i] starts a note
//   of `duration` cycles on channel i. While the note plays, a per-channel
//   divider advances an 8-bit-style sawtooth (wave) once every period_i cycles.
//   The registered DAC output carries the wave of the lowest-index busy channel.
//   A rising edge on mute_toggle flips the mute mode. Entering mute silences
//   and idles every channel.
//
// Optional feature:
//   SOUND_ENGINE_MIX_EN - when defined, dac_out is the saturating sum of the
//   waves of all busy channels instead of the priority selection.
//
// Ports:
//   clk          in   1                  rising-edge clock
//   rst          in   1                  asynchronous active-high reset
//   trig         in   CHANNELS           per-channel note request (rising edge)
//   period       in   CHANNELS*PERIOD_W  channel i step period at [i*PERIOD_W +: PERIOD_W]
//   duration     in   DUR_W              note length in cycles, sampled at start
//   mute_toggle  in   1                  rising edge toggles mute mode
//   dac_out      out  DAC_W              registered sawtooth sample
//   busy         out  CHANNELS           channel i is playing
//   muted        out  1                  mute mode active
module sound_engine #(
    parameter int CHANNELS = 4,
    parameter int PERIOD_W = 8,
    parameter int DUR_W    = 16,
    parameter int DAC_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          trig,
    input  logic [CHANNELS*PERIOD_W-1:0] period,
    input  logic [DUR_W-1:0]             duration,
    input  logic                         mute_toggle,
    output logic [DAC_W-1:0]             dac_out,
    output logic [CHANNELS-1:0]          busy,
    output logic                         muted
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    localparam logic [PERIOD_W-1:0] P_ONE = 1;
    localparam logic [DUR_W-1:0]    D_ONE = 1;
    localparam logic [DAC_W-1:0]    W_ONE = 1;

    // Per-channel state
    state_t              r_state   [CHANNELS];
    logic [DUR_W-1:0]    r_dur_cnt [CHANNELS];
    logic [PERIOD_W-1:0] r_div_cnt [CHANNELS];
    logic [DAC_W-1:0]    r_wave    [CHANNELS];

    state_t              w_state_nxt [CHANNELS];
    logic [DUR_W-1:0]    w_dur_nxt   [CHANNELS];
    logic [PERIOD_W-1:0] w_div_nxt   [CHANNELS];
    logic [DAC_W-1:0]    w_wave_nxt  [CHANNELS];

    // Divider/wave values for one PLAY step, independent of start/stop
    logic [PERIOD_W-1:0] w_per       [CHANNELS];
    logic [PERIOD_W-1:0] w_div_step  [CHANNELS];
    logic [DAC_W-1:0]    w_wave_step [CHANNELS];

    // Edge detection and mute control
    logic [CHANNELS-1:0] r_trig_q;
    logic                r_mute_q;
    logic                r_muted;
    // Cleared by reset; suppresses starts on the first edge after release so a
    // trig already held high must fall and rise again before it plays.
    logic                r_armed;
    logic [DAC_W-1:0]    r_dac;

    logic [CHANNELS-1:0] w_start;
    logic [CHANNELS-1:0] w_start_ok;
    logic                w_mute_rise;
    logic                w_mute_enter;
    logic                w_muted_nxt;
    logic [DAC_W-1:0]    w_dac_nxt;

    assign w_start      = trig & ~r_trig_q & {CHANNELS{r_armed}};
    assign w_start_ok   = w_start & {CHANNELS{(duration != '0) && !r_muted}};
    assign w_mute_rise  = mute_toggle & ~r_mute_q;
    assign w_mute_enter = w_mute_rise & ~r_muted;
    assign w_muted_nxt  = r_muted ^ w_mute_rise;

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_ch
            assign w_per[g] = period[g*PERIOD_W +: PERIOD_W];
            assign busy[g]  = (r_state[g] == S_PLAY);
        end
    endgenerate

    // One divider step using the current-cycle period; a zero period pins
    // the wave at 0 while the note still times out normally.
    always_comb begin : p_step
        for (int i = 0; i < CHANNELS; i++) begin
            w_div_step[i]  = '0;
            w_wave_step[i] = '0;
            if (w_per[i] == '0) begin
                w_div_step[i]  = '0;
                w_wave_step[i] = '0;
            end else if (r_div_cnt[i] == (w_per[i] - P_ONE)) begin
                w_div_step[i]  = '0;
                w_wave_step[i] = r_wave[i] + W_ONE;
            end else begin
                w_div_step[i]  = r_div_cnt[i] + P_ONE;
                w_wave_step[i] = r_wave[i];
            end
        end
    end

    // Channel next-state logic
    always_comb begin : p_fsm_nxt
        for (int i = 0; i < CHANNELS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_dur_nxt[i]   = r_dur_cnt[i];
            w_div_nxt[i]   = r_div_cnt[i];
            w_wave_nxt[i]  = r_wave[i];
            case (r_state[i])
                S_IDLE: begin
                    if (w_start_ok[i] && !w_mute_enter) begin
                        w_state_nxt[i] = S_PLAY;
                        w_dur_nxt[i]   = duration;
                        w_div_nxt[i]   = '0;
                        w_wave_nxt[i]  = '0;
                    end
                end
                S_PLAY: begin
                    if (w_mute_enter) begin
                        w_state_nxt[i] = S_IDLE;
                        w_dur_nxt[i]   = '0;
                        w_div_nxt[i]   = '0;
                        w_wave_nxt[i]  = '0;
                    end else if (w_start_ok[i]) begin
                        // Retrigger: only the length restarts; the tone keeps running.
                        w_dur_nxt[i]  = duration;
                        w_div_nxt[i]  = w_div_step[i];
                        w_wave_nxt[i] = w_wave_step[i];
                    end else if (r_dur_cnt[i] == D_ONE) begin
                        w_state_nxt[i] = S_IDLE;
                        w_dur_nxt[i]   = '0;
                        w_div_nxt[i]   = '0;
                        w_wave_nxt[i]  = '0;
                    end else begin
                        w_dur_nxt[i]  = r_dur_cnt[i] - D_ONE;
                        w_div_nxt[i]  = w_div_step[i];
                        w_wave_nxt[i] = w_wave_step[i];
                    end
                end
                default: begin
                    w_state_nxt[i] = S_IDLE;
                    w_dur_nxt[i]   = '0;
                    w_div_nxt[i]   = '0;
                    w_wave_nxt[i]  = '0;
                end
            endcase
        end
    end

    // DAC sample selection. Uses the post-edge mute value so the output goes
    // silent on the same edge that enters mute.
`ifdef SOUND_ENGINE_MIX_EN
    localparam int SUM_W = DAC_W + 4;
    localparam logic [SUM_W-1:0] SUM_MAX = {{(SUM_W-DAC_W){1'b0}}, {DAC_W{1'b1}}};

    logic [SUM_W-1:0] w_sum;

    always_comb begin : p_dac_mix
        w_sum     = '0;
        w_dac_nxt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_state[i] == S_PLAY) begin
                w_sum = w_sum + {{(SUM_W-DAC_W){1'b0}}, r_wave[i]};
            end
        end
        if (w_muted_nxt) begin
            w_dac_nxt = '0;
        end else if (w_sum > SUM_MAX) begin
            w_dac_nxt = '1;
        end else begin
            w_dac_nxt = w_sum[DAC_W-1:0];
        end
    end
`else
    always_comb begin : p_dac_pri
        w_dac_nxt = '0;
        // Walk downward so the lowest-index busy channel wins.
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (r_state[i] == S_PLAY) begin
                w_dac_nxt = r_wave[i];
            end
        end
        if (w_muted_nxt) begin
            w_dac_nxt = '0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin : p_regs
        if (rst) begin
            r_trig_q <= '0;
            r_mute_q <= 1'b0;
            r_muted  <= 1'b0;
            r_armed  <= 1'b0;
            r_dac    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i]   <= S_IDLE;
                r_dur_cnt[i] <= '0;
                r_div_cnt[i] <= '0;
                r_wave[i]    <= '0;
            end
        end else begin
            r_trig_q <= trig;
            r_mute_q <= mute_toggle;
            r_muted  <= w_muted_nxt;
            r_armed  <= 1'b1;
            r_dac    <= w_dac_nxt;
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i]   <= w_state_nxt[i];
                r_dur_cnt[i] <= w_dur_nxt[i];
                r_div_cnt[i] <= w_div_nxt[i];
                r_wave[i]    <= w_wave_nxt[i];
            end
        end
    end

    assign dac_out = r_dac;
    assign muted   = r_muted;

endmodule

// File: tb/tb_sound_engine.sv
// tb/tb_sound_engine.sv - randomized self-checking bench for sound_engine
module tb_sound_engine;

    logic        clk;
    logic        rst;
    logic [3:0]  trig;
    logic [31:0] period;
    logic [15:0] duration;
    logic        mute_toggle;
    logic [7:0]  dac_out;
    logic [3:0]  busy;
    logic        muted;

    int n_checks;
    int n_fail;

    sound_engine #(
        .CHANNELS (4),
        .PERIOD_W (8),
        .DUR_W    (16),
        .DAC_W    (8)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .trig        (trig),
        .period      (period),
        .duration    (duration),
        .mute_toggle (mute_toggle),
        .dac_out     (dac_out),
        .busy        (busy),
        .muted       (muted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: notes as (playing, cycles left, divider, wave) tuples
    bit        m_play [4];
    int        m_rem  [4];
    int        m_div  [4];
    int        m_wave [4];
    bit [3:0]  m_trig_q;
    bit        m_mute_q;
    bit        m_muted;
    bit        m_armed;
    int        m_dac;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [3:0] m_busy();
        bit [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = m_play[i];
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_play[i] = 0; m_rem[i] = 0; m_div[i] = 0; m_wave[i] = 0;
        end
        m_trig_q = '0; m_mute_q = 0; m_muted = 0; m_armed = 0; m_dac = 0;
    endtask

    task automatic advance(input int i, input int per);
        if (per == 0) begin
            m_div[i] = 0; m_wave[i] = 0;
        end else if (m_div[i] == per - 1) begin
            m_div[i] = 0; m_wave[i] = (m_wave[i] + 1) % 256;
        end else begin
            m_div[i] = (m_div[i] + 1) % 256;
        end
    endtask

    // Applies one clock edge of behaviour to the model, using the inputs now applied
    task automatic model_step();
        bit [3:0] st;
        bit rise, enter, mnext, ok;
        int per;
        st    = m_armed ? (trig & ~m_trig_q) : 4'b0;
        rise  = mute_toggle && !m_mute_q;
        enter = rise && !m_muted;
        mnext = m_muted ^ rise;
        m_dac = 0;
        if (!mnext) begin
            for (int i = 3; i >= 0; i--) if (m_play[i]) m_dac = m_wave[i];
        end
        for (int i = 0; i < 4; i++) begin
            per = int'(period[i*8 +: 8]);
            ok  = st[i] && (duration != 0) && !m_muted;
            if (enter) begin
                m_play[i] = 0; m_div[i] = 0; m_wave[i] = 0;
            end else if (m_play[i]) begin
                if (ok) begin
                    m_rem[i] = int'(duration);
                    advance(i, per);
                end else if (m_rem[i] == 1) begin
                    m_play[i] = 0; m_div[i] = 0; m_wave[i] = 0;
                end else begin
                    m_rem[i] = m_rem[i] - 1;
                    advance(i, per);
                end
            end else if (ok) begin
                m_play[i] = 1; m_rem[i] = int'(duration); m_div[i] = 0; m_wave[i] = 0;
            end
        end
        m_trig_q = trig; m_mute_q = mute_toggle; m_muted = mnext; m_armed = 1;
    endtask

    // One clock cycle: inputs are already applied at the falling edge
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("busy", 32'(busy), 32'(m_busy()));
        check("dac_out", 32'(dac_out), 32'(m_dac));
        check("muted", 32'(muted), 32'(m_muted));
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Asynchronous reset pulse between edges, checking outputs before any edge
    task automatic pulse_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_async_dac"}, 32'(dac_out), 32'd0);
        check({tag, "_async_busy"}, 32'(busy), 32'd0);
        check({tag, "_async_muted"}, 32'(muted), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    int       dac_seq [12];
    int       busy_cnt;
    int       exp_seq [10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0; trig = '0; period = '0; duration = '0; mute_toggle = 1'b0;
        model_reset();
        #1;
        rst = 1'b1;
        #1;
        check("reset_dac", 32'(dac_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_muted", 32'(muted), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        ticks(2);

        // Single note: period 3, duration 10
        period[7:0] = 8'd3; duration = 16'd10; trig = 4'b0001;
        busy_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            dac_seq[k] = int'(dac_out);
            if (busy[0]) busy_cnt++;
        end
        check("note_busy_len", 32'(busy_cnt), 32'd10);
        for (int k = 0; k < 10; k++) check("note_dac_seq", 32'(dac_seq[k+1]), 32'(exp_seq[k]));
        check("note_dac_end", 32'(dac_seq[11]), 32'd0);

        // Reset mid-note, then trig held high across release
        trig = 4'b0000; tick();
        trig = 4'b0001; ticks(4);
        pulse_reset("midnote");
        ticks(5);
        check("held_trig_no_note", 32'(busy), 32'd0);
        trig = 4'b0000; tick();

        // Priority: ch2 (period 5) long, ch0 (period 2) shorter
        period = {8'd0, 8'd5, 8'd0, 8'd2};
        duration = 16'd30; trig = 4'b0100; ticks(3);
        duration = 16'd10; trig = 4'b0101; ticks(35);
        trig = 4'b0000; tick();

        // Retrigger of ch1 at cycle 5 of an 8-cycle note
        period[15:8] = 8'd2; duration = 16'd8; trig = 4'b0010; ticks(3);
        trig = 4'b0000; ticks(2);
        trig = 4'b0010;
        busy_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (busy[1]) busy_cnt++;
        end
        check("retrig_busy_len", 32'(busy_cnt), 32'd8);
        trig = 4'b0000; tick();

        // Mute while two channels play, trig while muted, unmute
        duration = 16'd40; trig = 4'b0011; ticks(6);
        mute_toggle = 1'b1; tick();
        check("mute_busy", 32'(busy), 32'd0);
        check("mute_flag", 32'(muted), 32'd1);
        check("mute_dac", 32'(dac_out), 32'd0);
        mute_toggle = 1'b0; trig = 4'b0000; tick();
        trig = 4'b0100; ticks(3);
        check("muted_trig_ignored", 32'(busy), 32'd0);
        trig = 4'b0000; mute_toggle = 1'b1; tick();
        check("unmute_flag", 32'(muted), 32'd0);
        mute_toggle = 1'b0; trig = 4'b0100; ticks(3);
        check("unmute_plays", 32'(busy[2]), 32'd1);
        trig = 4'b0000; ticks(45);

        // Zero period and zero duration
        period[7:0] = 8'd0; duration = 16'd4; trig = 4'b0001;
        busy_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (busy[0]) busy_cnt++;
        end
        check("zero_period_busy", 32'(busy_cnt), 32'd4);
        trig = 4'b0000; duration = 16'd0; tick();
        trig = 4'b0001; ticks(3);
        check("zero_dur_idle", 32'(busy), 32'd0);
        trig = 4'b0000; tick();

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) trig[i] = ~trig[i];
                if ($urandom_range(0, 49) == 0) period[i*8 +: 8] = 8'($urandom_range(0, 6));
            end
            if ($urandom_range(0, 9) == 0) duration = 16'($urandom_range(0, 25));
            if ($urandom_range(0, 39) == 0) mute_toggle = ~mute_toggle;
            if ($urandom_range(0, 499) == 0) pulse_reset("rand_rst");
            else tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
